// File: rtl/prime_buf_pkg.sv
// Shared definitions for the prime generator and its output buffer: request FSM
// encodings and the prime width derived from WIDTH_LOG.
package prime_buf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HALT = 2'd3
  } state_t;

  function automatic int width_of(input int width_log);
    return 1 << width_log;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: a push is visible at head one cycle later; head/level are registered.
// Pop while empty is ignored; the writer must not push while full.
module sync_fifo #(
  parameter int WIDTH     = 16,
  parameter int DEPTH_LOG = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     head,
  output logic [DEPTH_LOG:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic                 do_pop;

  assign do_pop = pop && (level != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/prime_buf.sv
// Requests primes one at a time from the generator and queues them for a valid/ready consumer.
// A request is only issued with a free FIFO slot; a generator error halts requests until reset.
module prime_buf
  import prime_buf_pkg::*;
#(
  parameter int WIDTH_LOG = 4,
  parameter int DEPTH_LOG = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  output logic                            gen_go,
  input  logic                            gen_ready,
  input  logic                            gen_error,
  input  logic [width_of(WIDTH_LOG)-1:0]  gen_res,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [width_of(WIDTH_LOG)-1:0]  out_data,
  output logic [DEPTH_LOG:0]              level,
  output logic                            exhausted
);

  localparam int WIDTH = width_of(WIDTH_LOG);
  localparam logic [DEPTH_LOG:0] FULL = (DEPTH_LOG + 1)'(1 << DEPTH_LOG);

  state_t state;
  state_t state_nxt;
  logic   push;
  logic   set_exhausted;

  always_comb begin
    state_nxt     = state;
    push          = 1'b0;
    set_exhausted = 1'b0;
    case (state)
      IDLE: begin
        // Reserving a slot before asking guarantees the later push always fits.
        if (!exhausted && (level < FULL) && gen_ready) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (gen_ready) begin
          if (gen_error) begin
            set_exhausted = 1'b1;
            state_nxt     = HALT;
          end else begin
            push      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gen_go    <= 1'b0;
      exhausted <= 1'b0;
    end else begin
      state  <= state_nxt;
      gen_go <= (state_nxt == REQ);
      if (set_exhausted) begin
        exhausted <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH_LOG (DEPTH_LOG)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (gen_res),
    .pop       (out_ready),
    .head      (out_data),
    .level     (level)
  );

  assign out_valid = (level != '0);

endmodule

// File: tb/tb_prime_buf.sv
// Two buffers (16-bit and 8-bit primes) each fed by a behavioural prime generator;
// popped values are scored against a queue filled as the generator model delivers results.
module tb_prime_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- instance A: WIDTH_LOG=4 ----------------
  logic        rst_a_n, g_rst_a, out_ready_a;
  logic        gen_go_a, out_valid_a, exhausted_a;
  logic        ga_ready, ga_error, ga_busy, ga_fresh;
  logic [15:0] ga_res, out_data_a;
  logic [2:0]  level_a;
  int          ga_cur, ga_dly, na;

  // ---------------- instance B: WIDTH_LOG=3 ----------------
  logic        rst_b_n, g_rst_b, out_ready_b;
  logic        gen_go_b, out_valid_b, exhausted_b;
  logic        gb_ready, gb_error, gb_busy;
  logic [7:0]  gb_res, out_data_b;
  logic [2:0]  level_b;
  int          gb_cur, gb_dly, nb;

  int qa[$];
  int qb[$];
  int pa_log[$];
  int pop_a, pop_b, go_a, go_b, last_a, last_b, snap;

  prime_buf #(.WIDTH_LOG(4), .DEPTH_LOG(2)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .gen_go(gen_go_a), .gen_ready(ga_ready),
    .gen_error(ga_error), .gen_res(ga_res), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_data(out_data_a), .level(level_a),
    .exhausted(exhausted_a)
  );

  prime_buf #(.WIDTH_LOG(3), .DEPTH_LOG(2)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .gen_go(gen_go_b), .gen_ready(gb_ready),
    .gen_error(gb_error), .gen_res(gb_res), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_data(out_data_b), .level(level_b),
    .exhausted(exhausted_b)
  );

  function automatic int next_prime(input int c);
    int  n;
    bit  isp;
    n = c;
    do begin
      n++;
      isp = 1'b1;
      for (int d = 2; d * d <= n; d++) begin
        if (n % d == 0) isp = 1'b0;
      end
    end while (!isp);
    return n;
  endfunction

  // Generator model A: ready registered, variable latency, starts with res=1.
  always @(posedge clk) begin
    ga_fresh <= 1'b0;
    if (g_rst_a) begin
      ga_ready <= 1'b1; ga_error <= 1'b0; ga_res <= 16'd1; ga_cur <= 1; ga_busy <= 1'b0;
    end else if (ga_busy) begin
      if (ga_dly == 0) begin
        ga_busy  <= 1'b0;
        ga_ready <= 1'b1;
        ga_fresh <= 1'b1;
        na = next_prime(ga_cur);
        if (na >= 65536) begin
          ga_error <= 1'b1;
        end else begin
          ga_res <= 16'(na);
          ga_cur <= na;
          qa.push_back(na);
        end
      end else begin
        ga_dly <= ga_dly - 1;
      end
    end else if (gen_go_a && ga_ready && !ga_error) begin
      ga_ready <= 1'b0; ga_busy <= 1'b1; ga_dly <= $urandom_range(0, 3);
    end
  end

  // Generator model B: same behaviour over 8-bit primes; 257 overflows into error.
  always @(posedge clk) begin
    if (g_rst_b) begin
      gb_ready <= 1'b1; gb_error <= 1'b0; gb_res <= 8'd1; gb_cur <= 1; gb_busy <= 1'b0;
    end else if (gb_busy) begin
      if (gb_dly == 0) begin
        gb_busy  <= 1'b0;
        gb_ready <= 1'b1;
        nb = next_prime(gb_cur);
        if (nb >= 256) begin
          gb_error <= 1'b1;
        end else begin
          gb_res <= 8'(nb);
          gb_cur <= nb;
          qb.push_back(nb);
        end
      end else begin
        gb_dly <= gb_dly - 1;
      end
    end else if (gen_go_b && gb_ready && !gb_error) begin
      gb_ready <= 1'b0; gb_busy <= 1'b1; gb_dly <= $urandom_range(0, 3);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Scores the pop about to happen at the next rising edge, then advances to the next falling edge.
  task automatic tick();
    int e;
    if (out_valid_a && out_ready_a) begin
      e = (qa.size() > 0) ? qa.pop_front() : -1;
      chk("pop_a", int'(out_data_a), e);
      last_a = out_data_a; pa_log.push_back(int'(out_data_a)); pop_a++;
    end
    if (out_valid_b && out_ready_b) begin
      e = (qb.size() > 0) ? qb.pop_front() : -1;
      chk("pop_b", int'(out_data_b), e);
      last_b = out_data_b; pop_b++;
    end
    if (gen_go_a) go_a++;
    if (gen_go_b) go_b++;
    @(negedge clk);
  endtask

  task automatic reset_a();
    out_ready_a = 1'b0; rst_a_n = 1'b0; g_rst_a = 1'b1;
    tick(); tick();
    qa.delete(); pa_log.delete(); pop_a = 0;
    rst_a_n = 1'b1; g_rst_a = 1'b0;
  endtask

  task automatic reset_b();
    out_ready_b = 1'b0; rst_b_n = 1'b0; g_rst_b = 1'b1;
    tick(); tick();
    qb.delete(); pop_b = 0;
    rst_b_n = 1'b1; g_rst_b = 1'b0;
  endtask

  initial begin
    int exp6[6];
    exp6 = '{2, 3, 5, 7, 11, 13};
    pop_a = 0; pop_b = 0; go_a = 0; go_b = 0; last_a = 0; last_b = 0;
    rst_a_n = 1'b0; rst_b_n = 1'b0; g_rst_a = 1'b1; g_rst_b = 1'b1;
    out_ready_a = 1'b0; out_ready_b = 1'b0;
    @(negedge clk);
    tick(); tick();
    chk("rst_gen_go", int'(gen_go_a), 0);
    chk("rst_out_valid", int'(out_valid_a), 0);
    chk("rst_level", int'(level_a), 0);
    chk("rst_exhausted", int'(exhausted_a), 0);
    qa.delete(); qb.delete();
    rst_a_n = 1'b1; rst_b_n = 1'b1; g_rst_a = 1'b0; g_rst_b = 1'b0;

    // Free-running consumer: first six primes, never the idle value 1.
    out_ready_a = 1'b1;
    for (int i = 0; i < 1000 && pop_a < 6; i++) tick();
    chk("seq_count", int'(pop_a >= 6), 1);
    for (int i = 0; i < 6; i++) chk("seq_value", (i < pa_log.size()) ? pa_log[i] : -1, exp6[i]);

    // Blocked consumer: fill to DEPTH, no requests while full, one pop -> one request.
    reset_a();
    for (int i = 0; i < 500 && level_a != 3'd4; i++) tick();
    chk("fill_level", int'(level_a), 4);
    snap = go_a;
    repeat (20) tick();
    chk("full_no_go", go_a - snap, 0);
    chk("full_head", int'(out_data_a), 2);
    chk("full_valid", int'(out_valid_a), 1);
    snap = go_a;
    out_ready_a = 1'b1; tick(); out_ready_a = 1'b0;
    for (int i = 0; i < 200 && level_a != 3'd4; i++) tick();
    repeat (10) tick();
    chk("refill_one_go", go_a - snap, 1);
    chk("refill_level", int'(level_a), 4);
    snap = pop_a;
    out_ready_a = 1'b1;
    for (int i = 0; i < 50 && pop_a - snap < 4; i++) tick();
    out_ready_a = 1'b0;
    chk("refill_last", last_a, 11);

    // Push and pop on the same edge at level 2.
    reset_a();
    for (int i = 0; i < 300 && !(level_a == 3'd2 && ga_fresh); i++) tick();
    chk("pp_found", int'(level_a == 3'd2 && ga_fresh), 1);
    out_ready_a = 1'b1; tick(); out_ready_a = 1'b0;
    chk("pp_level", int'(level_a), 2);
    chk("pp_head", int'(out_data_a), 3);
    snap = pop_a;
    out_ready_a = 1'b1;
    for (int i = 0; i < 50 && pop_a - snap < 2; i++) tick();
    out_ready_a = 1'b0;
    chk("pp_order", last_a, 5);

    // Reset while a request is in flight.
    reset_a();
    for (int i = 0; i < 300 && !(level_a == 3'd2 && gen_go_a); i++) tick();
    tick();
    rst_a_n = 1'b0; g_rst_a = 1'b1;
    #1;
    chk("midrst_level", int'(level_a), 0);
    chk("midrst_valid", int'(out_valid_a), 0);
    chk("midrst_go", int'(gen_go_a), 0);
    chk("midrst_exh", int'(exhausted_a), 0);
    @(negedge clk);
    tick();
    qa.delete(); pa_log.delete(); pop_a = 0;
    rst_a_n = 1'b1; g_rst_a = 1'b0;
    out_ready_a = 1'b1;
    for (int i = 0; i < 500 && pop_a < 3; i++) tick();
    out_ready_a = 1'b0;
    for (int i = 0; i < 3; i++) chk("midrst_seq", (i < pa_log.size()) ? pa_log[i] : -1, exp6[i]);

    // 8-bit range: every prime below 256, then error and permanent halt.
    reset_b();
    out_ready_b = 1'b1;
    for (int i = 0; i < 5000 && !(exhausted_b && !out_valid_b); i++) tick();
    chk("exh_flag", int'(exhausted_b), 1);
    chk("exh_count", pop_b, 54);
    chk("exh_last", last_b, 251);
    snap = go_b;
    repeat (30) tick();
    chk("exh_no_go", go_b - snap, 0);
    chk("exh_level", int'(level_b), 0);

    // Exhaustion with entries still queued, then drain.
    reset_b();
    out_ready_b = 1'b1;
    for (int i = 0; i < 5000 && pop_b < 51; i++) tick();
    out_ready_b = 1'b0;
    for (int i = 0; i < 500 && !exhausted_b; i++) tick();
    chk("q_exh_flag", int'(exhausted_b), 1);
    chk("q_level", int'(level_b), 3);
    chk("q_head", int'(out_data_b), 239);
    snap = go_b;
    repeat (10) tick();
    chk("q_no_go", go_b - snap, 0);
    out_ready_b = 1'b1;
    for (int i = 0; i < 50 && out_valid_b; i++) tick();
    chk("q_count", pop_b, 54);
    chk("q_last", last_b, 251);
    chk("q_valid", int'(out_valid_b), 0);
    chk("q_exh_sticky", int'(exhausted_b), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
